param_rom_arbiter: RTL and testbench
====================================

PARAM_ROM_ARBITER -- requirements
Module: param_rom_arbiter

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, bits per parameter element.
REQ-002 SHALL have parameter SIZE, default 26, ROM depth in rows; AW = clogb2(SIZE).
REQ-003 SHALL have parameter NUM_REQ, default 4, number of requesters (LSTM gates i,f,g,o); IW = clogb2(NUM_REQ).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester burst request level.
REQ-007 SHALL have port req_addr  input  NUM_REQ*AW  per-requester start row, slice k = requester k.
REQ-008 SHALL have port req_len  input  NUM_REQ*AW  per-requester beat count minus 1.
REQ-009 SHALL have port grant  output  NUM_REQ  one-hot acceptance pulse, one cycle.
REQ-010 SHALL have port rom_rd  output  1  ROM read enable (ROM write enable held low).
REQ-011 SHALL have port rom_addr  output  AW  ROM row address.
REQ-012 SHALL have port rom_data  input  BIT_WIDTH*SIZE  ROM read data, valid 1 cycle after rom_rd.
REQ-013 SHALL have port rsp_valid  output  1  response beat valid.
REQ-014 SHALL have port rsp_id  output  IW  owner of current beat.
REQ-015 SHALL have port rsp_data  output  BIT_WIDTH*SIZE  rom_data passed through, unregistered.
REQ-016 SHALL have port rsp_last  output  1  final beat of burst.
REQ-017 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE.
REQ-019 SHALL, in IDLE with any req high, pulse grant for the selected requester, latch its req_addr/req_len, and enter ISSUE next cycle.
REQ-020 SHALL, in ISSUE, assert rom_rd every cycle, rom_addr starting at latched address, incrementing by 1 per cycle, for req_len+1 cycles.
REQ-021 SHALL wrap rom_addr from SIZE-1 to 0; lengths above SIZE-1 saturate to SIZE beats.
REQ-022 SHALL enter DRAIN after the last issue cycle, then IDLE one cycle later; no new grant while busy.
REQ-023 SHALL assert rsp_valid exactly one cycle after each rom_rd, with rsp_id = granted index and rsp_last on the final beat only.
REQ-024 SHALL treat a req deasserted before grant as withdrawn; req changes after grant SHALL not affect the burst.
REQ-025 SHALL ignore rom_data when rsp_valid is low; rsp_data is don't-care then.
REQ-026 SHALL, with round-robin selection, give the lowest index priority after reset and thereafter search from the index after the last granted one.
REQ-027 SHALL achieve back-to-back throughput of one beat per cycle within a burst, with a 2-cycle gap (DRAIN, IDLE) between bursts.

Reset
REQ-028 SHALL, on rst high, asynchronously force IDLE, grant=0, rom_rd=0, rom_addr=0, rsp_valid=0, rsp_id=0, rsp_last=0, busy=0, round-robin pointer to index 0.
REQ-029 SHALL abandon any in-flight burst on reset without emitting rsp_last; first grant possible in the first cycle after rst falls.

Configuration
REQ-030 SHALL honour macro PARAM_ROM_ARB_FIXED_PRIORITY_EN: defined -> fixed priority, lowest requesting index always wins, no pointer register; undefined -> round-robin per REQ-026.

Verification
REQ-031 SHALL cover: req=4'b0001, addr 3, len 2 -> grant 0001 one cycle, rom_addr 3,4,5, rsp_valid 3 beats, rsp_last on 3rd, id 0.
REQ-032 SHALL cover: addr 24, len 3 -> rom_addr 24,25,0,1.
REQ-033 SHALL cover: req=4'b1111 held, len 0 each, round-robin build -> grant order 0,1,2,3,0; fixed-priority build -> 0,0,0.
REQ-034 SHALL cover: rst asserted on 2nd beat of a 5-beat burst -> rom_rd, rsp_valid drop immediately, no rsp_last, busy=0.
REQ-035 SHALL cover: req pulsed one cycle while busy, dropped before IDLE -> no grant to that requester.

Source files
------------

// File: rtl/param_rom_arbiter.sv
// Arbitrates NUM_REQ burst readers onto one parameter-ROM read port, one beat per cycle.
// Define PARAM_ROM_ARB_FIXED_PRIORITY_EN for fixed lowest-index priority; round-robin otherwise.
module param_rom_arbiter #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned SIZE      = 26,
    parameter int unsigned NUM_REQ   = 4,
    localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*AW-1:0]     req_addr,
    input  logic [NUM_REQ*AW-1:0]     req_len,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      rom_rd,
    output logic [AW-1:0]             rom_addr,
    input  logic [BIT_WIDTH*SIZE-1:0] rom_data,
    output logic                      rsp_valid,
    output logic [IW-1:0]             rsp_id,
    output logic [BIT_WIDTH*SIZE-1:0] rsp_data,
    output logic                      rsp_last,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [AW-1:0] LAST_ROW = AW'(SIZE - 1);

    state_t               state, state_d;
    logic [AW-1:0]        cnt, cnt_d, rom_addr_d;
    logic [IW-1:0]        owner, owner_d, rsp_id_d;
    logic [NUM_REQ-1:0]   grant_d;
    logic                 rom_rd_d, rsp_valid_d, rsp_last_d, busy_d;
    logic                 found;
    logic [IW-1:0]        win;
    logic [AW-1:0]        win_addr, win_len_raw, win_len;
    int                   idx;
`ifndef PARAM_ROM_ARB_FIXED_PRIORITY_EN
    logic [IW-1:0]        ptr, ptr_d;
`endif

    // Requester selection: first requesting index starting from the search origin.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
`ifdef PARAM_ROM_ARB_FIXED_PRIORITY_EN
            idx = i;
`else
            idx = (int'(ptr) + i) % int'(NUM_REQ);
`endif
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign win_addr    = req_addr[win*AW +: AW];
    assign win_len_raw = req_len[win*AW +: AW];
    // Bursts never exceed one full pass over the ROM.
    assign win_len     = (win_len_raw > LAST_ROW) ? LAST_ROW : win_len_raw;

    assign rsp_data = rom_data;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        rom_addr_d  = rom_addr;
        owner_d     = owner;
        rsp_id_d    = rsp_id;
        grant_d     = '0;
        rom_rd_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
`ifndef PARAM_ROM_ARB_FIXED_PRIORITY_EN
        ptr_d       = ptr;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_d[win] = 1'b1;
                    owner_d      = win;
                    rom_addr_d   = win_addr;
                    cnt_d        = win_len;
                    rom_rd_d     = 1'b1;
                    state_d      = ISSUE;
`ifndef PARAM_ROM_ARB_FIXED_PRIORITY_EN
                    ptr_d        = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
`endif
                end
            end
            ISSUE: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = owner;
                rsp_last_d  = (cnt == '0);
                if (cnt == '0) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d      = cnt - AW'(1);
                    rom_rd_d   = 1'b1;
                    rom_addr_d = (rom_addr >= LAST_ROW) ? '0 : rom_addr + AW'(1);
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= '0;
            grant     <= '0;
            rom_rd    <= 1'b0;
            rom_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_last  <= 1'b0;
            busy      <= 1'b0;
`ifndef PARAM_ROM_ARB_FIXED_PRIORITY_EN
            ptr       <= '0;
`endif
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            owner     <= owner_d;
            grant     <= grant_d;
            rom_rd    <= rom_rd_d;
            rom_addr  <= rom_addr_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_last  <= rsp_last_d;
            busy      <= busy_d;
`ifndef PARAM_ROM_ARB_FIXED_PRIORITY_EN
            ptr       <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_param_rom_arbiter.sv
// Scoreboard bench for param_rom_arbiter; expected beats queued at request time, checked as they appear.
// Honours PARAM_ROM_ARB_FIXED_PRIORITY_EN for the arbitration-order expectations.
module tb_param_rom_arbiter;

    localparam int unsigned BW   = 8;
    localparam int unsigned SIZE = 26;
    localparam int unsigned NR   = 4;
    localparam int unsigned AW   = 5;
    localparam int unsigned IW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        req;
    logic [NR*AW-1:0]     req_addr, req_len;
    logic [NR-1:0]        grant;
    logic                 rom_rd;
    logic [AW-1:0]        rom_addr;
    logic [BW*SIZE-1:0]   rom_data;
    logic                 rsp_valid;
    logic [IW-1:0]        rsp_id;
    logic [BW*SIZE-1:0]   rsp_data;
    logic                 rsp_last;
    logic                 busy;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic          last;
    } beat_t;

    beat_t exp_iss[$];
    beat_t exp_rsp[$];
    beat_t mon_e;
    int    checks   = 0;
    int    failures = 0;

    param_rom_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .grant     (grant),
        .rom_rd    (rom_rd),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [BW*SIZE-1:0] rom_word(input logic [AW-1:0] a);
        logic [BW-1:0] b;
        b = BW'(a) * BW'(7) + BW'(17);
        return {SIZE{b}};
    endfunction

    // ROM model: one-cycle read latency, filler pattern when not reading.
    always @(posedge clk) rom_data <= rom_rd ? rom_word(rom_addr) : {SIZE{8'hEE}};

    always @(negedge clk) begin
        if (!rst) begin
            if (rom_rd) begin
                checks++;
                if (exp_iss.size() == 0) begin
                    failures++;
                    $display("FAIL issue_unexpected rom_addr=%0d, no issue expected", rom_addr);
                end else begin
                    mon_e = exp_iss.pop_front();
                    if (rom_addr !== mon_e.addr) begin
                        failures++;
                        $display("FAIL issue_addr rom_addr=%0d, required %0d", rom_addr, mon_e.addr);
                    end
                end
            end
            if (rsp_valid) begin
                checks++;
                if (exp_rsp.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected id=%0d last=%0b, no beat expected", rsp_id, rsp_last);
                end else begin
                    mon_e = exp_rsp.pop_front();
                    if (rsp_id !== mon_e.id || rsp_last !== mon_e.last || rsp_data !== rom_word(mon_e.addr)) begin
                        failures++;
                        $display("FAIL rsp_beat id=%0d last=%0b data=%h, required id=%0d last=%0b data=%h",
                                 rsp_id, rsp_last, rsp_data, mon_e.id, mon_e.last, rom_word(mon_e.addr));
                    end
                end
            end
        end
    end

    task automatic set_req(input int k, input int addr, input int len);
        req_addr[k*AW +: AW] = AW'(addr);
        req_len[k*AW +: AW]  = AW'(len);
        req[k]               = 1'b1;
    endtask

    task automatic push_burst(input int id, input int addr, input int len);
        int    n;
        int    a;
        beat_t b;
        n = ((len > int'(SIZE) - 1) ? int'(SIZE) - 1 : len) + 1;
        a = addr;
        for (int i = 0; i < n; i++) begin
            b.addr = AW'(a);
            b.id   = IW'(id);
            b.last = (i == n - 1);
            exp_iss.push_back(b);
            exp_rsp.push_back(b);
            a = (a + 1) % int'(SIZE);
        end
    endtask

    task automatic wait_grant(output logic [NR-1:0] g, output int cyc);
        g   = '0;
        cyc = 0;
        while (g === '0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            g = grant;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 60) begin
            @(negedge clk);
            n++;
            if (!busy && exp_rsp.size() == 0 && exp_iss.size() == 0) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; req_addr = '0; req_len = '0;
        repeat (2) @(negedge clk);
        checks++; if (grant !== '0)    begin failures++; $display("FAIL reset_grant got %b, required 0", grant); end
        checks++; if (rom_rd !== 1'b0) begin failures++; $display("FAIL reset_rom_rd got %b, required 0", rom_rd); end
        checks++; if (rom_addr !== '0) begin failures++; $display("FAIL reset_rom_addr got %0d, required 0", rom_addr); end
        checks++; if (rsp_valid !== 1'b0 || rsp_last !== 1'b0 || rsp_id !== '0) begin
            failures++; $display("FAIL reset_rsp valid=%b last=%b id=%0d, required all 0", rsp_valid, rsp_last, rsp_id);
        end
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got %b, required 0", busy); end
        #2 rst = 1'b0;
    endtask

    task automatic test_single;
        logic [NR-1:0] g; int cyc; bit ok;
        @(negedge clk);
        set_req(0, 3, 2); push_burst(0, 3, 2);
        wait_grant(g, cyc);
        checks++; if (g !== 4'b0001 || cyc != 1) begin
            failures++; $display("FAIL single_grant got %b after %0d cycles, required 0001 after 1", g, cyc);
        end
        req = '0;
        @(negedge clk);
        checks++; if (grant !== '0 || busy !== 1'b1) begin
            failures++; $display("FAIL single_grant_pulse grant=%b busy=%b, required 0000 and 1", grant, busy);
        end
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_drain busy=%b pending=%0d, required idle 0", busy, exp_rsp.size()); end
    endtask

    task automatic test_wrap;
        logic [NR-1:0] g; int cyc; bit ok;
        @(negedge clk);
        set_req(2, 24, 3); push_burst(2, 24, 3);
        wait_grant(g, cyc);
        checks++; if (g !== 4'b0100) begin failures++; $display("FAIL wrap_grant got %b, required 0100", g); end
        req = '0;
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_drain busy=%b pending=%0d, required idle 0", busy, exp_rsp.size()); end
        @(negedge clk);
        set_req(1, 10, 31); push_burst(1, 10, 31);
        wait_grant(g, cyc);
        checks++; if (g !== 4'b0010) begin failures++; $display("FAIL sat_grant got %b, required 0010", g); end
        req = '0;
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL sat_drain busy=%b pending=%0d, required idle 0", busy, exp_rsp.size()); end
    endtask

    task automatic test_back_to_back;
        logic [NR-1:0] g; int cyc; bit ok;
        int order[$];
`ifdef PARAM_ROM_ARB_FIXED_PRIORITY_EN
        order = '{0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #2 rst = 1'b0;
        for (int k = 0; k < int'(NR); k++) set_req(k, k * 5, 0);
        foreach (order[i]) push_burst(order[i], order[i] * 5, 0);
        foreach (order[i]) begin
            wait_grant(g, cyc);
            checks++; if (g !== NR'(1) << order[i]) begin
                failures++; $display("FAIL arb_order grant #%0d got %b, required index %0d", i, g, order[i]);
            end
            if (i > 0) begin
                checks++; if (cyc != 3) begin
                    failures++; $display("FAIL arb_gap grant #%0d after %0d cycles, required 3", i, cyc);
                end
            end
        end
        req = '0;
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL arb_drain busy=%b pending=%0d, required idle 0", busy, exp_rsp.size()); end
    endtask

    task automatic test_reset_midburst;
        logic [NR-1:0] g; int cyc; bit ok;
        @(negedge clk);
        set_req(0, 0, 4); push_burst(0, 0, 4);
        wait_grant(g, cyc);
        req = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (rom_rd !== 1'b0 || rsp_valid !== 1'b0 || rsp_last !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midburst_reset rom_rd=%b rsp_valid=%b rsp_last=%b busy=%b, required all 0",
                                 rom_rd, rsp_valid, rsp_last, busy);
        end
        exp_iss.delete(); exp_rsp.delete();
        @(negedge clk);
        #2;
        set_req(1, 7, 0); push_burst(1, 7, 0);
        rst = 1'b0;
        wait_grant(g, cyc);
        checks++; if (g !== 4'b0010 || cyc != 1) begin
            failures++; $display("FAIL post_reset_grant got %b after %0d cycles, required 0010 after 1", g, cyc);
        end
        req = '0;
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL post_reset_drain busy=%b pending=%0d, required idle 0", busy, exp_rsp.size()); end
    endtask

    task automatic test_withdraw;
        logic [NR-1:0] g; int cyc; int extra; bit ok;
        @(negedge clk);
        set_req(0, 12, 4); push_burst(0, 12, 4);
        wait_grant(g, cyc);
        checks++; if (g !== 4'b0001) begin failures++; $display("FAIL withdraw_first_grant got %b, required 0001", g); end
        req = '0;
        @(negedge clk); set_req(3, 20, 1);
        @(negedge clk); req = '0;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (grant !== '0) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL withdraw_grant got %0d grants, required 0", extra); end
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL withdraw_drain busy=%b pending=%0d, required idle 0", busy, exp_rsp.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_reset_midburst();
        test_withdraw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
